smem_irq_gate: RTL and testbench
================================

SMEM_IRQ_GATE -- requirements
Module: smem_irq_gate

Interface
REQ-001 SHALL have parameter SMEM_BASE, default 16'hE000, first secure-memory (SMEM) address.
REQ-002 SHALL have parameter SMEM_SIZE, default 16'h1000, SMEM size in bytes.
REQ-003 SHALL have parameter MAX_HOLD, default 16'd4096, maximum consecutive cycles IRQs may be held.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pc, input, 16, current program counter.
REQ-007 SHALL have port irq_in, input, 14, raw interrupt requests from peripherals.
REQ-008 SHALL have port irq_acc, input, 14, per-line interrupt accept pulses from the CPU.
REQ-009 SHALL have port irq_out, output, 14, gated interrupt requests to the CPU.
REQ-010 SHALL have port irq_pend, output, 14, currently held requests.
REQ-011 SHALL have port violation, output, 1, sticky hold-timeout violation flag.

Function
REQ-012 SHALL compute in_smem combinationally as SMEM_BASE <= pc <= SMEM_BASE+SMEM_SIZE-2, unsigned 16-bit compare.
REQ-013 SHALL implement states IDLE, HOLD, DRAIN and VIOL, registered on the rising edge of clk.
REQ-014 IDLE: irq_out SHALL equal irq_in; next state SHALL be HOLD if in_smem, otherwise IDLE.
REQ-015 irq_out SHALL be 14'h0 in any cycle where in_smem=1, independent of state, so that masking takes effect in the same cycle as SMEM entry.
REQ-016 HOLD: each cycle, irq_pend SHALL be updated as irq_pend | irq_in; next state SHALL be DRAIN when in_smem=0 and irq_pend != 0, IDLE when in_smem=0 and irq_pend == 0, otherwise HOLD.
REQ-017 DRAIN: irq_out SHALL equal irq_pend | irq_in; a bit SHALL clear on irq_acc; next state SHALL be IDLE when irq_pend becomes 0, and HOLD on re-entry to SMEM with pending bits retained.
REQ-018 When irq_in and irq_acc are asserted on the same bit in the same cycle, set SHALL win over clear.
REQ-019 In IDLE, irq_pend SHALL remain 14'h0 and irq_acc SHALL be ignored.
REQ-020 VIOL: irq_out SHALL be 0 and violation SHALL be 1; the state SHALL be left only on rst_n or when pc == 16'hFFFE, which SHALL clear irq_pend and the counter and go to IDLE with violation=0.
REQ-021 Any transition into VIOL SHALL occur on the clock edge after the triggering condition, and irq_pend SHALL be cleared on entry.

Reset
REQ-022 On rst_n=0, the state SHALL go to IDLE asynchronously, with irq_pend=0, hold counter=0 and violation=0.
REQ-023 On reset assertion mid-HOLD or mid-DRAIN, all held requests SHALL be discarded, and no irq_out pulse SHALL result from them after release.
REQ-024 irq_out SHALL equal irq_in & {14{~in_smem}} while in reset.

Configuration
REQ-025 With macro SMEM_IRQ_GATE_TIMEOUT_EN defined, the design SHALL include a 16-bit hold counter that increments each HOLD cycle, clears on leaving HOLD, saturates, and on reaching MAX_HOLD goes to VIOL.
REQ-026 Without SMEM_IRQ_GATE_TIMEOUT_EN, the counter SHALL be absent, VIOL SHALL be unreachable, and violation SHALL be tied to 0.

Structure
REQ-027 The state encoding typedef (2-bit: IDLE, HOLD, DRAIN, VIOL), NUM_IRQ=14 and RESET_HANDLER=16'hFFFE SHALL reside in shared package smem_pkg.
REQ-028 The SMEM range decode SHALL be a sub-module smem_range_dec (pc in, in_smem out), reusable by other SMEM monitors.

Verification
REQ-029 With pc=16'hC000 and irq_in[3] pulsed for 1 cycle, irq_out[3] SHALL be high in the same cycle and irq_pend SHALL stay 0.
REQ-030 With pc=16'hE010 and irq_in[5] pulsed, irq_out SHALL be 0 and irq_pend[5]=1; after pc=16'hC000, irq_out[5] SHALL be 1 in DRAIN until irq_acc[5], then IDLE.
REQ-031 In HOLD with pending bits 2 and 7, a DRAIN where only irq_acc[2] fires followed by pc=16'hE100 SHALL return to HOLD with irq_pend=14'h0080.
REQ-032 With SMEM_IRQ_GATE_TIMEOUT_EN, MAX_HOLD=16 and pc held at 16'hE020 for 16 cycles, violation SHALL be 1 on the next edge, irq_out SHALL be 0, and pc=16'hFFFE SHALL return to IDLE with violation=0.
REQ-033 Boundary: pc=16'hEFFE SHALL mask irq_out, while pc=16'hEFFF, 16'hF000 and 16'hDFFE SHALL not.
REQ-034 Asserting rst_n=0 mid-DRAIN with irq_pend=14'h0011 SHALL immediately clear irq_pend, and no output pulse SHALL follow release.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared definitions for secure-memory (SMEM) monitors: address width,
// interrupt line count, reset handler address and the IRQ gate state type.
package smem_pkg;

    localparam int          ADDR_W        = 16;
    localparam int          NUM_IRQ       = 14;
    localparam logic [15:0] RESET_HANDLER = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_VIOL  = 2'd3
    } gate_state_e;

    // A request raised in the same cycle as its accept stays pending.
    function automatic logic [NUM_IRQ-1:0] set_wins_clear(
        input logic [NUM_IRQ-1:0] pend,
        input logic [NUM_IRQ-1:0] set,
        input logic [NUM_IRQ-1:0] clr
    );
        return (pend & ~clr) | set;
    endfunction

endpackage

// File: rtl/smem_range_dec.sv
// SMEM address-range decoder. The window ends two bytes before
// SMEM_BASE+SMEM_SIZE so that only word-aligned fetch addresses that lie
// wholly inside the region count as SMEM.
module smem_range_dec
    import smem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SMEM_BASE = 16'hE000,
    parameter logic [ADDR_W-1:0] SMEM_SIZE = 16'h1000
) (
    input  logic [ADDR_W-1:0] pc,
    output logic              in_smem
);

    localparam logic [ADDR_W-1:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

    assign in_smem = (pc >= SMEM_BASE) && (pc <= SMEM_LAST);

endmodule

// File: rtl/smem_irq_gate.sv
// Interrupt gate for secure memory. While the CPU executes from SMEM all
// interrupts are masked and collected; once execution leaves SMEM the
// collected requests are replayed until the CPU accepts each one.
// Optional feature macro: SMEM_IRQ_GATE_TIMEOUT_EN adds a hold-time
// counter that forces a sticky violation state when SMEM keeps interrupts
// blocked for MAX_HOLD consecutive cycles.
module smem_irq_gate
    import smem_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE = 16'hE000,
    parameter logic [15:0] SMEM_SIZE = 16'h1000,
    parameter logic [15:0] MAX_HOLD  = 16'd4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        pc,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_acc,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic               violation
);

    logic               in_smem;
    gate_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_out_c;

    smem_range_dec #(
        .SMEM_BASE (SMEM_BASE),
        .SMEM_SIZE (SMEM_SIZE)
    ) u_range_dec (
        .pc      (pc),
        .in_smem (in_smem)
    );

`ifdef SMEM_IRQ_GATE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        hold_expired;

    // Saturating count of consecutive HOLD cycles including the current one.
    always_comb begin
        cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        hold_expired = (state_q == ST_HOLD) && in_smem && (cnt_inc >= MAX_HOLD);
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    // Next-state, pending-set and gated-output decode.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        irq_out_c = '0;
        unique case (state_q)
            ST_IDLE: begin
                irq_out_c = irq_in;
                pend_d    = '0;
                if (in_smem) begin
                    // The request masked on the entry cycle is kept, not lost.
                    state_d = ST_HOLD;
                    pend_d  = irq_in;
                end
            end
            ST_HOLD: begin
                pend_d    = pend_q | irq_in;
                irq_out_c = pend_q | irq_in;
                if (!in_smem) begin
                    state_d = (pend_d != '0) ? ST_DRAIN : ST_IDLE;
                end
`ifdef SMEM_IRQ_GATE_TIMEOUT_EN
                if (hold_expired) begin
                    state_d = ST_VIOL;
                    pend_d  = '0;
                end
`endif
            end
            ST_DRAIN: begin
                irq_out_c = pend_q | irq_in;
                if (in_smem) begin
                    // Output is masked on re-entry, so accepts cannot apply.
                    state_d = ST_HOLD;
                    pend_d  = pend_q | irq_in;
                end else begin
                    pend_d  = set_wins_clear(pend_q, irq_in, irq_acc);
                    state_d = (pend_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_VIOL: begin
                pend_d = '0;
                if (pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase
        if (in_smem) begin
            irq_out_c = '0;
        end
        if (state_q == ST_VIOL) begin
            irq_out_c = '0;
        end
    end

`ifdef SMEM_IRQ_GATE_TIMEOUT_EN
    // Counter runs only while staying in HOLD and restarts on every entry.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
            cnt_d = cnt_inc;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign violation = (state_q == ST_VIOL);
`else
    assign violation = 1'b0;
`endif

    // Gate state and pending-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign irq_out  = irq_out_c;
    assign irq_pend = pend_q;

endmodule

// File: tb/tb_smem_irq_gate.sv
module tb_smem_irq_gate;

    localparam logic [15:0] BASE = 16'hE000;
    localparam logic [15:0] SIZE = 16'h1000;
    localparam logic [15:0] MAXH = 16'd16;
`ifdef SMEM_IRQ_GATE_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [13:0] irq_in;
    logic [13:0] irq_acc;
    logic [13:0] irq_out;
    logic [13:0] irq_pend;
    logic        violation;

    int n_tests;
    int n_fail;

    // Reference model: "was executing from SMEM last cycle", pending mask,
    // violation flag and the length of the current SMEM stay.
    bit          m_inside;
    bit          m_viol;
    logic [13:0] m_pend;
    int          m_cnt;

    smem_irq_gate #(
        .SMEM_BASE (BASE),
        .SMEM_SIZE (SIZE),
        .MAX_HOLD  (MAXH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .irq_in    (irq_in),
        .irq_acc   (irq_acc),
        .irq_out   (irq_out),
        .irq_pend  (irq_pend),
        .violation (violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_range(input logic [15:0] p);
        return (int'(p) >= int'(BASE)) && (int'(p) <= int'(BASE) + int'(SIZE) - 2);
    endfunction

    function automatic logic [13:0] exp_out();
        if (m_viol || in_range(pc)) return 14'h0;
        return m_pend | irq_in;
    endfunction

    function automatic void model_reset();
        m_inside = 1'b0;
        m_viol   = 1'b0;
        m_pend   = '0;
        m_cnt    = 0;
    endfunction

    function automatic void model_edge();
        bit ins;
        ins = in_range(pc);
        if (!rst_n) begin
            model_reset();
        end else if (m_viol) begin
            if (pc == 16'hFFFE) model_reset();
        end else if (m_inside) begin
            m_pend = m_pend | irq_in;
            if (ins) begin
                if (m_cnt < 65535) m_cnt++;
                if (TIMEOUT && m_cnt >= int'(MAXH)) begin
                    m_viol = 1'b1; m_pend = '0; m_inside = 1'b0; m_cnt = 0;
                end
            end else begin
                m_inside = 1'b0; m_cnt = 0;
            end
        end else if (ins) begin
            m_pend = m_pend | irq_in; m_inside = 1'b1; m_cnt = 0;
        end else if (m_pend != 14'h0) begin
            m_pend = (m_pend & ~irq_acc) | irq_in;
        end
    endfunction

    task automatic drive(input logic [15:0] p, input logic [13:0] i, input logic [13:0] a);
        @(negedge clk);
        pc = p; irq_in = i; irq_acc = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        pc = 16'hC000; irq_in = '0; irq_acc = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; pc = 16'hE010; irq_in = 14'h3FFF; irq_acc = '0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL rst_out_smem: got %h expected %h", irq_out, 14'h0); end
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL rst_pend: got %h expected %h", irq_pend, 14'h0); end
        n_tests++; if (violation !== 1'b0) begin n_fail++; $display("FAIL rst_viol: got %b expected 0", violation); end
        pc = 16'hC000;
        #1;
        n_tests++; if (irq_out !== 14'h3FFF) begin n_fail++; $display("FAIL rst_out_pass: got %h expected %h", irq_out, 14'h3FFF); end
        @(posedge clk);
        #1;
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL rst_pend_edge: got %h expected %h", irq_pend, 14'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        irq_in = '0;
    endtask

    task automatic test_pass_through();
        do_reset();
        drive(16'hC000, 14'h0008, 14'h0);
        n_tests++; if (irq_out !== 14'h0008) begin n_fail++; $display("FAIL pass_out: got %h expected %h", irq_out, 14'h0008); end
        tick();
        drive(16'hC000, 14'h0, 14'h0);
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL pass_pend: got %h expected %h", irq_pend, 14'h0); end
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL pass_out_off: got %h expected %h", irq_out, 14'h0); end
        tick();
    endtask

    task automatic test_hold_drain();
        do_reset();
        drive(16'hE010, 14'h0, 14'h0); tick();
        drive(16'hE010, 14'h0020, 14'h0);
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL hold_mask: got %h expected %h", irq_out, 14'h0); end
        tick();
        drive(16'hE010, 14'h0, 14'h0);
        n_tests++; if (irq_pend !== 14'h0020) begin n_fail++; $display("FAIL hold_pend: got %h expected %h", irq_pend, 14'h0020); end
        tick();
        drive(16'hC000, 14'h0, 14'h0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(16'hC000, 14'h0, 14'h0);
            n_tests++; if (irq_out !== 14'h0020) begin n_fail++; $display("FAIL drain_out: got %h expected %h", irq_out, 14'h0020); end
            tick();
        end
        drive(16'hC000, 14'h0, 14'h0020);
        n_tests++; if (irq_out !== 14'h0020) begin n_fail++; $display("FAIL drain_out_acc: got %h expected %h", irq_out, 14'h0020); end
        tick();
        drive(16'hC000, 14'h0, 14'h0);
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL drain_done_pend: got %h expected %h", irq_pend, 14'h0); end
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL drain_done_out: got %h expected %h", irq_out, 14'h0); end
        tick();
        // Back in IDLE: stray accepts must not matter, requests pass straight through.
        drive(16'hC000, 14'h0100, 14'h3FFF);
        n_tests++; if (irq_out !== 14'h0100 || irq_pend !== 14'h0) begin n_fail++; $display("FAIL idle_after_drain: got out %h pend %h expected out %h pend %h", irq_out, irq_pend, 14'h0100, 14'h0); end
        tick();
    endtask

    task automatic test_partial_ack();
        do_reset();
        drive(16'hE100, 14'h0, 14'h0); tick();
        drive(16'hE100, 14'h0084, 14'h0); tick();
        drive(16'hC000, 14'h0, 14'h0); tick();
        drive(16'hC000, 14'h0, 14'h0004);
        n_tests++; if (irq_out !== 14'h0084) begin n_fail++; $display("FAIL part_drain_out: got %h expected %h", irq_out, 14'h0084); end
        tick();
        // Same-bit set and accept in one cycle: the set must survive.
        drive(16'hC000, 14'h0001, 14'h0001);
        n_tests++; if (irq_pend !== 14'h0080) begin n_fail++; $display("FAIL part_pend_after_ack: got %h expected %h", irq_pend, 14'h0080); end
        tick();
        drive(16'hE100, 14'h0, 14'h0);
        n_tests++; if (irq_pend !== 14'h0081) begin n_fail++; $display("FAIL set_wins: got %h expected %h", irq_pend, 14'h0081); end
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL part_reenter_out: got %h expected %h", irq_out, 14'h0); end
        tick();
        drive(16'hE100, 14'h0, 14'h0001);
        n_tests++; if (irq_pend !== 14'h0081) begin n_fail++; $display("FAIL part_hold_pend: got %h expected %h", irq_pend, 14'h0081); end
        tick();
    endtask

    task automatic test_boundary();
        logic [15:0] pcs [4];
        logic [13:0] exps [4];
        pcs[0] = 16'hEFFE; exps[0] = 14'h0;
        pcs[1] = 16'hEFFF; exps[1] = 14'h2AAA;
        pcs[2] = 16'hF000; exps[2] = 14'h2AAA;
        pcs[3] = 16'hDFFE; exps[3] = 14'h2AAA;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            drive(pcs[k], 14'h2AAA, 14'h0);
            n_tests++; if (irq_out !== exps[k]) begin n_fail++; $display("FAIL boundary_%h: got %h expected %h", pcs[k], irq_out, exps[k]); end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef SMEM_IRQ_GATE_TIMEOUT_EN
        // One IDLE entry cycle plus MAXH HOLD cycles, then the violation edge.
        for (int k = 0; k <= int'(MAXH); k++) begin
            drive(16'hE020, 14'(1 << (k % 14)), 14'h0);
            n_tests++; if (violation !== 1'b0 || irq_out !== 14'h0) begin n_fail++; $display("FAIL to_early: got viol %b out %h expected viol 0 out 0", violation, irq_out); end
            tick();
        end
        drive(16'hE020, 14'h0, 14'h0);
        n_tests++; if (violation !== 1'b1) begin n_fail++; $display("FAIL to_viol: got %b expected 1", violation); end
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL to_pend_clr: got %h expected %h", irq_pend, 14'h0); end
        tick();
        drive(16'hC000, 14'h3FFF, 14'h0);
        n_tests++; if (irq_out !== 14'h0 || violation !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got out %h viol %b expected out 0 viol 1", irq_out, violation); end
        tick();
        drive(16'hFFFE, 14'h3FFF, 14'h0);
        n_tests++; if (irq_out !== 14'h0) begin n_fail++; $display("FAIL to_exit_out: got %h expected %h", irq_out, 14'h0); end
        tick();
        drive(16'hC000, 14'h0001, 14'h0);
        n_tests++; if (violation !== 1'b0 || irq_out !== 14'h0001) begin n_fail++; $display("FAIL to_recover: got viol %b out %h expected viol 0 out 0001", violation, irq_out); end
        tick();
`else
        for (int k = 0; k < 40; k++) begin
            drive(16'hE020, 14'h0, 14'h0);
            n_tests++; if (violation !== 1'b0) begin n_fail++; $display("FAIL no_timeout_viol: got %b expected 0", violation); end
            tick();
        end
        drive(16'hC000, 14'h0002, 14'h0);
        n_tests++; if (irq_out !== 14'h0002) begin n_fail++; $display("FAIL no_timeout_exit: got %h expected %h", irq_out, 14'h0002); end
        tick();
`endif
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive(16'hE010, 14'h0011, 14'h0); tick();
        drive(16'hC000, 14'h0, 14'h0); tick();
        drive(16'hC000, 14'h0, 14'h0);
        n_tests++; if (irq_pend !== 14'h0011) begin n_fail++; $display("FAIL mid_pend_before: got %h expected %h", irq_pend, 14'h0011); end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (irq_pend !== 14'h0) begin n_fail++; $display("FAIL mid_pend_async: got %h expected %h", irq_pend, 14'h0); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(16'hC000, 14'h0, 14'h0);
            n_tests++; if (irq_out !== 14'h0 || irq_pend !== 14'h0) begin n_fail++; $display("FAIL mid_no_pulse: got out %h pend %h expected 0 0", irq_out, irq_pend); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        logic [15:0] cur;
        logic [13:0] ri, ra;
        int bad;
        pool[0] = 16'hC000; pool[1] = 16'hE000; pool[2] = 16'hE010; pool[3] = 16'hEFFE;
        pool[4] = 16'hEFFF; pool[5] = 16'hF000; pool[6] = 16'hDFFE; pool[7] = 16'hFFFE;
        do_reset();
        cur = 16'hC000;
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur = ($urandom_range(0, 4) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
            end
            ri = ($urandom_range(0, 2) == 0) ? 14'(1 << $urandom_range(0, 13)) : 14'h0;
            ra = ($urandom_range(0, 1) == 0) ? 14'($urandom) : 14'h0;
            drive(cur, ri, ra);
            n_tests++;
            if (irq_out !== exp_out() || irq_pend !== m_pend || violation !== m_viol) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand_cycle_%0d: got out %h pend %h viol %b expected out %h pend %h viol %b",
                                       k, irq_out, irq_pend, violation, exp_out(), m_pend, m_viol);
                bad++;
            end
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        test_reset();
        test_pass_through();
        test_hold_drain();
        test_partial_ack();
        test_boundary();
        test_timeout();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
